// File: rtl/upsample_sequencer.sv
// Symbol scheduler feeding the upsampler: pulls I/Q pairs over valid/ready and
// strobes one symbol every sample_rate cycles, inserting zeros on underflow.
module upsample_sequencer #(
    parameter int DATA_W   = 4,
    parameter int RATE_W   = 4,
    parameter int UFLOW_W  = 8,
    parameter int MIN_RATE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [RATE_W-1:0]   rate_cfg,
    input  logic                sym_valid,
    output logic                sym_ready,
    input  logic [DATA_W-1:0]   sym_data_1,
    input  logic [DATA_W-1:0]   sym_data_2,
    output logic                new_symbol,
    output logic [DATA_W-1:0]   out_data_1,
    output logic [DATA_W-1:0]   out_data_2,
    output logic [RATE_W-1:0]   sample_rate,
    output logic                busy,
    output logic                rate_err,
    output logic [UFLOW_W-1:0]  underflow_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [RATE_W-1:0]  MIN_RATE_V = RATE_W'(MIN_RATE);
    localparam logic [UFLOW_W-1:0] UFLOW_MAX  = {UFLOW_W{1'b1}};

    state_t             state_q, state_d;
    logic [RATE_W-1:0]  cnt_q, cnt_d;
    logic [RATE_W-1:0]  sample_rate_q, sample_rate_d;
    logic               new_symbol_q, new_symbol_d;
    logic [DATA_W-1:0]  out_data_1_q, out_data_1_d;
    logic [DATA_W-1:0]  out_data_2_q, out_data_2_d;
    logic               busy_q, busy_d;
    logic               rate_err_q, rate_err_d;
    logic [UFLOW_W-1:0] uflow_q, uflow_d;

    logic               boundary;
    logic               xfer;
    logic               latch_rate;

    function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] r);
        return (r < MIN_RATE_V) ? MIN_RATE_V : r;
    endfunction

    function automatic logic [UFLOW_W-1:0] sat_inc(input logic [UFLOW_W-1:0] v);
        return (v == UFLOW_MAX) ? v : v + UFLOW_W'(1);
    endfunction

    // IDLE treats every cycle as a boundary so the first symbol is taken at once.
    assign boundary  = (state_q == IDLE) || (cnt_q == sample_rate_q - RATE_W'(1));
    assign sym_ready = enable && boundary;
    assign xfer      = sym_valid && sym_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sample_rate_d = sample_rate_q;
        new_symbol_d  = 1'b0;
        out_data_1_d  = out_data_1_q;
        out_data_2_d  = out_data_2_q;
        uflow_d       = uflow_q;
        latch_rate    = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer) begin
                    state_d      = RUN;
                    new_symbol_d = 1'b1;
                    out_data_1_d = sym_data_1;
                    out_data_2_d = sym_data_2;
                    latch_rate   = 1'b1;
                end
            end
            RUN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (enable) begin
                        new_symbol_d = 1'b1;
                        latch_rate   = 1'b1;
                        if (sym_valid) begin
                            out_data_1_d = sym_data_1;
                            out_data_2_d = sym_data_2;
                        end else begin
                            // Zero-stuff so the downstream cadence never slips.
                            out_data_1_d = '0;
                            out_data_2_d = '0;
                            uflow_d      = sat_inc(uflow_q);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + RATE_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch_rate) begin
            sample_rate_d = clamp_rate(rate_cfg);
        end
        rate_err_d = rate_err_q || (latch_rate && (rate_cfg < MIN_RATE_V));
        busy_d     = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            sample_rate_q <= MIN_RATE_V;
            new_symbol_q  <= 1'b0;
            out_data_1_q  <= '0;
            out_data_2_q  <= '0;
            busy_q        <= 1'b0;
            rate_err_q    <= 1'b0;
            uflow_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sample_rate_q <= sample_rate_d;
            new_symbol_q  <= new_symbol_d;
            out_data_1_q  <= out_data_1_d;
            out_data_2_q  <= out_data_2_d;
            busy_q        <= busy_d;
            rate_err_q    <= rate_err_d;
            uflow_q       <= uflow_d;
        end
    end

    assign new_symbol      = new_symbol_q;
    assign out_data_1      = out_data_1_q;
    assign out_data_2      = out_data_2_q;
    assign sample_rate     = sample_rate_q;
    assign busy            = busy_q;
    assign rate_err        = rate_err_q;
    assign underflow_count = uflow_q;

endmodule

// File: doc/upsample_sequencer.md
Name: upsample_sequencer

Overview:
- Symbol scheduler in front of the upsampler.
- Pulls I/Q symbol pairs from an upstream source over a valid/ready handshake.
- Emits them to the upsampler with a one-cycle new_symbol strobe exactly once every sample_rate cycles, and drives the sample_rate the upsampler uses.
- Inserts zero symbols on source underflow so the output symbol cadence never slips, and only applies rate changes on symbol boundaries.

Parameters:
- DATA_W, 4, width of each I/Q symbol component
- RATE_W, 4, width of the rate configuration
- UFLOW_W, 8, width of the saturating underflow counter
- MIN_RATE, 2, smallest legal upsample rate; smaller configured values are clamped to this

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run request; low stops the stream at the next symbol boundary
- rate_cfg  input  RATE_W  requested upsample rate
- sym_valid  input  1  upstream symbol available
- sym_ready  output  1  sequencer accepts symbol this cycle (combinational from state, counter and enable)
- sym_data_1  input  DATA_W  upstream I component
- sym_data_2  input  DATA_W  upstream Q component
- new_symbol  output  1  one-cycle strobe to upsampler, registered
- out_data_1  output  DATA_W  I symbol to upsampler, registered
- out_data_2  output  DATA_W  Q symbol to upsampler, registered
- sample_rate  output  RATE_W  active rate to upsampler, registered
- busy  output  1  high while in RUN
- rate_err  output  1  sticky; set when a latched rate_cfg is below MIN_RATE; cleared only by reset
- underflow_count  output  UFLOW_W  zero symbols inserted, saturating

Behaviour:
- Reset (async, rst_n low) values:
  - state=IDLE, cnt=0.
  - new_symbol=0, out_data_1=0, out_data_2=0.
  - sample_rate=MIN_RATE.
  - busy=0, rate_err=0, underflow_count=0.
  - Reset mid-stream discards any in-flight symbol, with no strobe afterwards.
- Transfer: occurs when sym_valid and sym_ready are both high at a rising edge. Symbol data is sampled on that edge.
- Rate latch: eff_rate = max(rate_cfg, MIN_RATE). It is latched into sample_rate only on a transfer or an underflow boundary, never mid-period. rate_err is set in the same cycle if rate_cfg < MIN_RATE.
- IDLE:
  - sym_ready = enable.
  - On a transfer: go to RUN, cnt<=0, new_symbol<=1, out_data<=sym_data, latch rate.
  - enable high with no sym_valid: stay in IDLE; no underflow is counted.
- RUN:
  - busy=1. cnt increments each cycle.
  - new_symbol is 1 only in the cycle after a boundary decision and 0 otherwise.
  - out_data holds its value between strobes.
  - sym_ready = enable and (cnt == sample_rate-1).
  - At cnt == sample_rate-1 with enable=1 and a transfer: cnt<=0, new_symbol<=1, out_data<=sym_data, latch rate.
  - At cnt == sample_rate-1 with enable=1 and no sym_valid (underflow): cnt<=0, new_symbol<=1, out_data<=0, latch rate, underflow_count increments (saturating at all-ones).
  - At cnt == sample_rate-1 with enable=0: go to IDLE, cnt<=0, no strobe, no underflow counted.
  - enable dropping mid-period has no effect until the boundary.
- Latency and cadence:
  - A transfer at edge T produces new_symbol high in cycle T+1.
  - Consecutive strobes in RUN are exactly sample_rate cycles apart, with sample_rate equal to the value latched at the preceding strobe.
- Simultaneous events:
  - A rate_cfg change at a boundary cycle takes effect for the period starting with that strobe.
  - Underflow and saturation in the same cycle: the counter holds at the maximum and the strobe is still issued.

Test Plan:
- Basic cadence: rate_cfg=4, enable=1, sym_valid always high with symbols (1,2),(3,4),(5,6). Required response: new_symbol pulses every 4 cycles carrying those values in order; sym_ready is high one cycle per period; the first strobe comes 1 cycle after the first transfer.
- Underflow: rate_cfg=3, a single symbol (7,9), then sym_valid=0 for 3 periods. Required response: strobes continue every 3 cycles with out_data=(0,0); underflow_count=3; busy stays 1.
- Rate change: rate_cfg switches 4→6 mid-period. Required response: the current period stays 4 cycles; the next strobe shows sample_rate=6 and the following gap is 6 cycles.
- Illegal rate: rate_cfg=1, then rate_cfg=0. Required response: sample_rate=2, strobe period 2, rate_err=1 and it remains 1 after rate_cfg returns to 5.
- Stop and saturation: enable drops at cnt=1 with rate 5. Required response: no further strobe, return to IDLE at the boundary, busy=0, sym_ready=0. Separately, force 260 underflows. Required response: underflow_count=255.
- Reset mid-stream: assert rst_n=0 asynchronously at cnt=2. Required response: all outputs are at reset values immediately; after release, nothing is emitted until a new transfer occurs.
